// File: rtl/fme_pkg.sv
// rtl/fme_pkg.sv - shared types and constants for the SATD scheduler
package fme_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_CLEAR,
        S_RESP
    } state_t;

    localparam int PIX_W  = 8;
    localparam int DIFF_W = 9;
    localparam int ACC_W  = 18;
    localparam int NPIX   = 16;
    localparam int BLK_W  = NPIX * PIX_W;
    localparam int SATD_W = 16;

    localparam logic [1:0] PU_LOAD  = 2'b01;
    localparam logic [1:0] PU_SHIFT = 2'b10;
    localparam logic [1:0] PU_CLEAR = 2'b11;

endpackage

// File: rtl/satd_sched_if.sv
// rtl/satd_sched_if.sv - requester, response and PU signal bundle for satd_sched
interface satd_sched_if
    import fme_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*BLK_W-1:0] req_ref;
    logic [NREQ*BLK_W-1:0] req_cur;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [ACC_W-1:0]      rsp_satd;
    logic                  busy;
    logic [1:0]            pu_sel;
    logic [DIFF_W-1:0]     pu_rc1;
    logic [DIFF_W-1:0]     pu_rc2;
    logic [DIFF_W-1:0]     pu_rc3;
    logic [DIFF_W-1:0]     pu_rc4;
    logic [SATD_W-1:0]     pu_satd;

    modport slave (
        input  req_valid, req_ref, req_cur, rsp_ready, pu_satd,
        output req_ready, rsp_valid, rsp_id, rsp_satd, busy,
               pu_sel, pu_rc1, pu_rc2, pu_rc3, pu_rc4
    );

    modport master (
        output req_valid, req_ref, req_cur, rsp_ready, pu_satd,
        input  req_ready, rsp_valid, rsp_id, rsp_satd, busy,
               pu_sel, pu_rc1, pu_rc2, pu_rc3, pu_rc4
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, priority moves past the last winner on accept
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] prio;
    logic [IDX_W-1:0] gnt_idx;
    logic             found;
    int               j;

    // scan requesters starting at the priority index, first asserted one wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(prio) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
                found   = 1'b1;
            end
        end
    end

    // after an accepted grant the requester following the winner gets priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= '0;
        end else if (advance) begin
            prio <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/satd_sched.sv
// rtl/satd_sched.sv - round-robin SATD block scheduler in front of one Hadamard PU
module satd_sched
    import fme_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int PU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    satd_sched_if.slave bus
);
    localparam int         ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] ACC_FIRST = 8'(PU_LAT);
    localparam logic [7:0] ACC_LAST  = 8'(PU_LAT + 3);

    state_t            state;
    logic [7:0]        cnt;
    logic [ACC_W-1:0]  acc;
    logic [DIFF_W-1:0] d_q   [NPIX];
    logic [DIFF_W-1:0] cap_d [NPIX];
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   win_idx;
    logic [BLK_W-1:0]  sel_ref;
    logic [BLK_W-1:0]  sel_cur;
    logic              accept;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    // requesters only see the grant while idle and out of reset
    assign bus.req_ready = (state == S_IDLE && rst) ? gnt : '0;
    assign accept        = |bus.req_ready;

    // route the granted requester's pixels to the difference stage
    always_comb begin
        sel_ref = '0;
        sel_cur = '0;
        win_idx = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt[r]) begin
                sel_ref = bus.req_ref[r*BLK_W +: BLK_W];
                sel_cur = bus.req_cur[r*BLK_W +: BLK_W];
                win_idx = ID_W'(r);
            end
        end
    end

    for (genvar k = 0; k < NPIX; k++) begin : g_diff
        assign cap_d[k] = {1'b0, sel_ref[k*PIX_W +: PIX_W]} - {1'b0, sel_cur[k*PIX_W +: PIX_W]};
    end

    // sequencer: capture, four row loads, drain with gated accumulation, PU clear, response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            acc          <= '0;
            bus.busy     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id   <= '0;
            bus.rsp_satd <= '0;
            bus.pu_sel   <= PU_CLEAR;
            bus.pu_rc1   <= '0;
            bus.pu_rc2   <= '0;
            bus.pu_rc3   <= '0;
            bus.pu_rc4   <= '0;
            for (int i = 0; i < NPIX; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        d_q        <= cap_d;
                        acc        <= '0;
                        cnt        <= '0;
                        bus.rsp_id <= win_idx;
                        bus.busy   <= 1'b1;
                        bus.pu_sel <= PU_LOAD;
                        bus.pu_rc1 <= cap_d[0];
                        bus.pu_rc2 <= cap_d[1];
                        bus.pu_rc3 <= cap_d[2];
                        bus.pu_rc4 <= cap_d[3];
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt == 8'd3) begin
                        state      <= S_DRAIN;
                        cnt        <= '0;
                        bus.pu_sel <= PU_SHIFT;
                        bus.pu_rc1 <= '0;
                        bus.pu_rc2 <= '0;
                        bus.pu_rc3 <= '0;
                        bus.pu_rc4 <= '0;
                    end else begin
                        cnt        <= cnt + 8'd1;
                        bus.pu_rc1 <= d_q[4];
                        bus.pu_rc2 <= d_q[5];
                        bus.pu_rc3 <= d_q[6];
                        bus.pu_rc4 <= d_q[7];
                        for (int i = 0; i < NPIX - 4; i++) begin
                            d_q[i] <= d_q[i+4];
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt >= ACC_FIRST) begin
                        acc <= acc + ACC_W'(bus.pu_satd);
                    end
                    if (cnt == ACC_LAST) begin
                        state      <= S_CLEAR;
                        cnt        <= '0;
                        bus.pu_sel <= PU_CLEAR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_CLEAR: begin
                    state         <= S_RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_satd  <= acc;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_satd_sched.sv
// tb/tb_satd_sched.sv - scoreboard bench for satd_sched with a behavioural Hadamard PU
module tb_satd_sched;
    localparam int NREQ   = 2;
    localparam int PU_LAT = 1;

    typedef struct packed {
        logic [7:0]  id;
        logic [17:0] satd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    satd_sched_if #(.NREQ(NREQ)) bus ();

    satd_sched #(.NREQ(NREQ), .PU_LAT(PU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int id, input int satd);
        mk = '{id: 8'(id), satd: 18'(satd)};
    endfunction

    // behavioural PU: rows shift in on 01, one |column| sum per 10 cycle, cleared on 11
    int pm [4][4];
    int sc = 0;
    int hm [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};

    function automatic int colsum(input int c);
        int s;
        int t;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    t += hm[i][r] * pm[r][k] * hm[c][k];
                end
            end
            s += (t < 0) ? -t : t;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        case (bus.pu_sel)
            2'b01: begin
                for (int r = 3; r > 0; r--) begin
                    for (int k = 0; k < 4; k++) pm[r][k] <= pm[r-1][k];
                end
                pm[0][0] <= int'($signed(bus.pu_rc1));
                pm[0][1] <= int'($signed(bus.pu_rc2));
                pm[0][2] <= int'($signed(bus.pu_rc3));
                pm[0][3] <= int'($signed(bus.pu_rc4));
            end
            2'b10: begin
                bus.pu_satd <= (sc < 4) ? 16'(colsum(sc)) : 16'd0;
                sc <= sc + 1;
            end
            default: begin
                sc <= 0;
                bus.pu_satd <= 16'd0;
                for (int r = 0; r < 4; r++) begin
                    for (int k = 0; k < 4; k++) pm[r][k] <= 0;
                end
            end
        endcase
    end

    // monitor: every response handshake pops one expected result
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_id", bus.rsp_id, e.id);
                check("rsp_satd", bus.rsp_satd, e.satd);
            end
        end
    end

    task automatic offer(input int r, input logic [127:0] rf, input logic [127:0] cr, output int acc_cyc);
        bus.req_ref[r*128 +: 128] = rf;
        bus.req_cur[r*128 +: 128] = cr;
        bus.req_valid[r] = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 300 && acc_cyc < 0; i++) begin
            @(negedge clk);
            if (bus.req_ready[r]) acc_cyc = cyc;
        end
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
        bus.req_ref[r*128 +: 128] = '1;
        if (acc_cyc < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.busy) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, (n < 500) ? 1 : 0, 1);
    endtask

    task automatic grant_seq(input int nblk);
        int k;
        k = 0;
        for (int i = 0; i < 100 * nblk && k < nblk; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                check("grant_order", bus.req_ready, (k % 2 == 0) ? 1 : 2);
                k++;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("grant_count", k, nblk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        int lat;
        int h;
        int a;
        logic [127:0] p10, p20, p48, pb, pzero, pfull;

        p10   = {16{8'd10}};
        p20   = {16{8'd20}};
        p48   = p20;
        p48[47:40] = 8'd23;
        pb    = p10;
        pb[7:0] = 8'd11;
        pzero = '0;
        pfull = {16{8'hFF}};

        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_ref   = '0;
        bus.req_cur   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_satd", bus.rsp_satd, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pu_sel", bus.pu_sel, 3);
        check("rst_pu_rc", {bus.pu_rc1, bus.pu_rc2, bus.pu_rc3, bus.pu_rc4}, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;

        // zero-difference block from requester 0, inputs scrambled and a withdrawn offer while busy
        sb_q.push_back(mk(0, 0));
        offer(0, p10, p10, c0);
        bus.req_ref[255:128] = pfull;
        bus.req_valid[1] = 1'b1;
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) lat = cyc - c0;
        end
        check("rsp_latency", lat, 11);
        wait_drain("zero");

        // single unit difference from requester 1
        sb_q.push_back(mk(1, 16));
        offer(1, pb, p10, c0);
        wait_drain("unit");

        // both requesters continuously valid for four blocks
        sb_q.push_back(mk(0, 48));
        sb_q.push_back(mk(1, 4080));
        sb_q.push_back(mk(0, 48));
        sb_q.push_back(mk(1, 4080));
        bus.req_ref = {pfull, p48};
        bus.req_cur = {pzero, p20};
        bus.req_valid = 2'b11;
        grant_seq(4);
        wait_drain("rr");

        // back-pressure with requester 1 pending
        bus.rsp_ready = 1'b0;
        sb_q.push_back(mk(0, 4080));
        offer(0, pzero, pfull, c0);
        bus.req_ref[255:128] = p48;
        bus.req_cur[255:128] = p20;
        bus.req_valid[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        for (int i = 0; i < 20; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_satd", bus.rsp_satd, 4080);
            check("bp_rsp_id", bus.rsp_id, 0);
            check("bp_req_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        sb_q.push_back(mk(1, 48));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        check("hs_no_accept", bus.req_ready, 0);
        a = -1;
        for (int i = 0; i < 20 && a < 0; i++) begin
            if (i > 0 || 1'b1) @(negedge clk);
            if (bus.req_ready[1]) a = cyc;
        end
        check("next_accept_gap", a - h, 1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_drain("bp");

        // reset in the middle of DRAIN discards the block and restores priority 0
        offer(0, p48, p20, c0);
        for (int i = 0; i < 20 && cyc < c0 + 6; i++) @(negedge clk);
        check("pre_rst_pu_sel", bus.pu_sel, 2);
        bus.req_valid[1] = 1'b1;
        rst = 1'b0;
        #1;
        check("mid_rst_req_ready", bus.req_ready, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_rsp_id", bus.rsp_id, 0);
        check("mid_rst_rsp_satd", bus.rsp_satd, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_pu_sel", bus.pu_sel, 3);
        check("mid_rst_pu_rc", {bus.pu_rc1, bus.pu_rc2, bus.pu_rc3, bus.pu_rc4}, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_idle", bus.busy, 0);
        sb_q.push_back(mk(0, 16));
        sb_q.push_back(mk(1, 4080));
        bus.req_ref = {pfull, pb};
        bus.req_cur = {pzero, p10};
        bus.req_valid = 2'b11;
        grant_seq(2);
        wait_drain("post_rst");

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
